// File: rtl/axi_err_slave.sv
// AXI default/error slave: terminates every read and write with DECERR.
// Define AXI_ERR_SLAVE_LOG_EN (simulation only) to print AW/AR handshakes.
module axi_err_slave #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [ADDR_WIDTH-1:0] awaddr,
   input  logic [ID_WIDTH-1:0]   awid,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic                  wlast,
   output logic                  bvalid,
   input  logic                  bready,
   output logic [1:0]            bresp,
   output logic [ID_WIDTH-1:0]   bid,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [ADDR_WIDTH-1:0] araddr,
   input  logic [ID_WIDTH-1:0]   arid,
   input  logic [7:0]            arlen,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic [ID_WIDTH-1:0]   rid
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t  w_state;
   r_state_t  r_state;
   logic [7:0] beat_cnt;
   logic [7:0] burst_len;

   assign bresp = 2'b11;
   assign rresp = 2'b11;
   assign rdata = '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_state <= W_IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
      end else begin
         case (w_state)
            W_IDLE: if (awvalid && awready) begin
               bid     <= awid;
               awready <= 1'b0;
               wready  <= 1'b1;
               w_state <= W_DATA;
            end
            W_DATA: if (wvalid && wready && wlast) begin
               wready  <= 1'b0;
               bvalid  <= 1'b1;
               w_state <= W_RESP;
            end
            W_RESP: if (bready) begin
               bvalid  <= 1'b0;
               awready <= 1'b1;
               w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // rlast is precomputed from the next counter value so it is valid with its beat
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= R_IDLE;
         arready   <= 1'b1;
         rvalid    <= 1'b0;
         rlast     <= 1'b0;
         rid       <= '0;
         beat_cnt  <= '0;
         burst_len <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid && arready) begin
               rid       <= arid;
               burst_len <= arlen;
               beat_cnt  <= '0;
               arready   <= 1'b0;
               rvalid    <= 1'b1;
               rlast     <= (arlen == 8'd0);
               r_state   <= R_DATA;
            end
            R_DATA: if (rready) begin
               if (rlast) begin
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
                  arready <= 1'b1;
                  r_state <= R_IDLE;
               end else begin
                  beat_cnt <= beat_cnt + 8'd1;
                  rlast    <= ((beat_cnt + 8'd1) == burst_len);
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

`ifdef AXI_ERR_SLAVE_LOG_EN
   always_ff @(posedge i_clk) begin
      if (i_rst_n && awvalid && awready)
         $display("axi_err_slave: AW addr=%h id=%h -> DECERR", awaddr, awid);
      if (i_rst_n && arvalid && arready)
         $display("axi_err_slave: AR addr=%h id=%h -> DECERR", araddr, arid);
   end
`else
   logic unused_addr;
   assign unused_addr = ^{awaddr, araddr};
`endif

endmodule

// File: tb/tb_axi_err_slave.sv
// Scoreboard bench for axi_err_slave: drivers queue expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi_err_slave;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned IW = 4;

   logic          clk, rst_n;
   logic          awvalid, awready, wvalid, wready, wlast;
   logic          bvalid, bready, arvalid, arready, rvalid, rready, rlast;
   logic [AW-1:0] awaddr, araddr;
   logic [IW-1:0] awid, bid, arid, rid;
   logic [1:0]    bresp, rresp;
   logic [7:0]    arlen;
   logic [DW-1:0] rdata;

   axi_err_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
   );

   typedef struct packed {
      logic [IW-1:0] id;
      logic          last;
   } rbeat_t;

   rbeat_t        rq[$];
   logic [IW-1:0] bq[$];
   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;
   bit            rand_rdy = 0;
   time           t_ar, t_aw;

   logic          r_stall = 0, b_stall = 0, r_stall_last;
   logic [IW-1:0] r_stall_id, b_stall_id, b_exp;
   rbeat_t        r_exp;

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every handshake against the queued expectation
   always @(negedge clk) begin
      if (!rst_n) begin
         r_stall = 0;
         b_stall = 0;
      end else begin
         if (r_stall) begin
            chk("r_hold_valid", rvalid, 1'b1);
            chk("r_hold_id", rid, r_stall_id);
            chk("r_hold_last", rlast, r_stall_last);
         end
         if (b_stall) begin
            chk("b_hold_valid", bvalid, 1'b1);
            chk("b_hold_id", bid, b_stall_id);
         end
         if (rvalid && rready) begin
            chk("r_beat_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
               r_exp = rq.pop_front();
               chk("rid", rid, r_exp.id);
               chk("rlast", rlast, r_exp.last);
               chk("rdata", rdata, '0);
               chk("rresp", rresp, 2'b11);
            end
         end
         if (bvalid && bready) begin
            chk("b_resp_expected", bq.size() != 0, 1'b1);
            if (bq.size() != 0) begin
               b_exp = bq.pop_front();
               chk("bid", bid, b_exp);
               chk("bresp", bresp, 2'b11);
            end
         end
         r_stall = rvalid && !rready;
         r_stall_id = rid;
         r_stall_last = rlast;
         b_stall = bvalid && !bready;
         b_stall_id = bid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) begin
         rready = 1'($urandom_range(0, 1));
         bready = 1'($urandom_range(0, 1));
      end
   end

   // All driver tasks start and end 1 time unit after a rising edge
   task automatic send_aw(input logic [IW-1:0] id);
      bit ok = 0;
      awvalid = 1; awid = id; awaddr = $urandom;
      bq.push_back(id);
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (awready) begin ok = 1; t_aw = $time; break; end
      end
      @(posedge clk); #1;
      awvalid = 0;
      chk("aw_accept", ok, 1'b1);
   endtask

   task automatic send_w(input int n, input bit gaps);
      for (int b = 0; b < n; b++) begin
         bit ok = 0;
         wvalid = 1; wlast = (b == n - 1);
         for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
         end
         @(posedge clk); #1;
         wvalid = 0; wlast = 0;
         chk("w_accept", ok, 1'b1);
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic send_ar(input logic [IW-1:0] id, input logic [7:0] len);
      bit ok = 0;
      for (int i = 0; i <= int'(len); i++) rq.push_back(rbeat_t'{id, (i == int'(len))});
      arvalid = 1; arid = id; arlen = len; araddr = $urandom;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (arready) begin ok = 1; t_ar = $time; break; end
      end
      @(posedge clk); #1;
      arvalid = 0;
      chk("ar_accept", ok, 1'b1);
   endtask

   task automatic drain(input int limit);
      bit ok = 0;
      for (int c = 0; c < limit; c++) begin
         if (rq.size() == 0 && bq.size() == 0) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("drain", ok, 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0;
      awvalid = 0; awaddr = '0; awid = '0; wvalid = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = '0; arid = '0; arlen = '0; rready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", awready, 1'b1);
      chk("rst_arready", arready, 1'b1);
      chk("rst_wready", wready, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rlast", rlast, 1'b0);
      chk("rst_bid", bid, '0);
      chk("rst_rid", rid, '0);
      @(posedge clk); #3 rst_n = 1;
      @(posedge clk); #1;

      // single-beat write, B one cycle after the W handshake
      bready = 1;
      send_aw(4'd3);
      send_w(1, 0);
      @(negedge clk);
      chk("b_latency", bvalid, 1'b1);
      @(posedge clk); #1;
      drain(20);

      // 4-beat read with rready high
      rready = 1;
      send_ar(4'd5, 8'd3);
      @(negedge clk);
      chk("r_latency", rvalid, 1'b1);
      @(posedge clk); #1;
      drain(20);

      // single-beat read held under backpressure
      rready = 0;
      send_ar(4'd7, 8'd0);
      repeat (5) begin
         @(negedge clk);
         chk("len0_rvalid", rvalid, 1'b1);
         chk("len0_rlast", rlast, 1'b1);
      end
      @(posedge clk); #1;
      rready = 1;
      drain(10);
      @(negedge clk);
      chk("len0_done", rvalid, 1'b0);
      @(posedge clk); #1;

      // simultaneous AR(len 255) and AW
      fork
         send_ar(4'hA, 8'd255);
         begin send_aw(4'h6); send_w(2, 0); end
      join
      chk("ar_aw_same_cycle", t_ar, t_aw);
      drain(1000);

      // W presented before AW must stall
      wvalid = 1; wlast = 1;
      repeat (3) begin
         @(negedge clk);
         chk("w_stall", wready, 1'b0);
      end
      @(posedge clk); #1;
      send_aw(4'h9);
      begin
         bit ok = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wready) begin ok = 1; break; end
         end
         @(posedge clk); #1;
         wvalid = 0; wlast = 0;
         chk("w_after_aw", ok, 1'b1);
      end
      drain(20);

      // reset during beat 2 of an 8-beat read
      rready = 1;
      send_ar(4'h2, 8'd7);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 0;
      #1 chk("rst_async_rvalid", rvalid, 1'b0);
      rq.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      @(negedge clk);
      chk("rst_rel_arready", arready, 1'b1);
      chk("rst_rel_rlast", rlast, 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("rst_no_resp", rvalid, 1'b0);
      end
      @(posedge clk); #1;

      // randomized concurrent traffic with random backpressure
      rand_rdy = 1;
      fork
         for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_aw(IW'($urandom_range(0, 15)));
            send_w(int'($urandom_range(1, 4)), 1);
         end
         for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_ar(IW'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
         end
      join
      drain(3000);
      rand_rdy = 0;
      rready = 1; bready = 1;
      repeat (2) begin @(posedge clk); #1; end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
